// File: rtl/out_channel_fifo_pkg.sv
// Shared definitions for the output-channel FIFO and its storage.
// Holds the default word width, the operation encoding used for the
// occupancy update, and sizing/pointer helper functions that are also
// used by the interpreter's array and heap sizing.
package out_channel_fifo_pkg;

  localparam int unsigned DefaultElementWidth = 12;

  // Buffer activity for one clock edge.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Bits needed to hold a value in the range 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer increment with explicit wrap, so depth need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/out_channel_fifo_circular_buffer_mem.sv
// circular_buffer_mem: Depth x Width storage for the output FIFO.
// One synchronous write port, one combinational read port. Contents
// are never reset; occupancy tracking lives in the parent.
// Ports:
//   clock   - write clock
//   wr_en   - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - combinational read data
module circular_buffer_mem
  import out_channel_fifo_pkg::*;
#(
  parameter int unsigned Width = DefaultElementWidth,
  parameter int unsigned Depth = 4
) (
  input  logic                         clock,
  input  logic                         wr_en,
  input  logic [ptr_width(Depth)-1:0]  wr_addr,
  input  logic [Width-1:0]             wr_data,
  input  logic [ptr_width(Depth)-1:0]  rd_addr,
  output logic [Width-1:0]             rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_channel_fifo.sv
// out_channel_fifo: buffered output channel behind the interpreter's
// `out` instruction. Accepts one word per cycle, holds up to NOut words,
// and presents them show-ahead to a drain consumer via valid/ready.
// Back-pressures the interpreter when full.
// Ports:
//   clock       - single clock, rising edge
//   reset       - synchronous active-high reset, highest priority
//   flush       - synchronous clear of contents; statistics kept
//   outValid    - interpreter presents outData this cycle
//   outData     - word from the `out` instruction
//   outReady    - buffer can accept a word (count < NOut)
//   drainValid  - a word is available on drainData
//   drainData   - oldest buffered word, 0 when empty
//   drainReady  - consumer takes drainData this cycle
//   count       - words currently buffered
//   lastOut     - most recently accepted word
//   totalOut    - words accepted since reset, saturating
module out_channel_fifo
  import out_channel_fifo_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultElementWidth,
  parameter int unsigned NOut               = 4,
  parameter int unsigned CountWidth         = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            outValid,
  input  logic [MemoryElementWidth-1:0]   outData,
  output logic                            outReady,
  output logic                            drainValid,
  output logic [MemoryElementWidth-1:0]   drainData,
  input  logic                            drainReady,
  output logic [count_width(NOut)-1:0]    count,
  output logic [MemoryElementWidth-1:0]   lastOut,
  output logic [CountWidth-1:0]           totalOut
);

  localparam int unsigned CW = count_width(NOut);
  localparam int unsigned PW = ptr_width(NOut);

  logic [CW-1:0]                 count_q, count_d;
  logic [PW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]                 wr_ptr_inc, rd_ptr_inc;
  logic [MemoryElementWidth-1:0] last_q;
  logic [CountWidth-1:0]         total_q;
  logic [MemoryElementWidth-1:0] rd_data;
  logic                          push, pop;
  fifo_op_e                      op;

  // Handshake depends on registered count only: no same-cycle bypass when full.
  assign outReady   = (count_q < CW'(NOut));
  assign drainValid = (count_q != '0);
  assign drainData  = drainValid ? rd_data : '0;

  assign push = outValid && outReady;
  assign pop  = drainValid && drainReady;
  assign op   = fifo_op_e'({pop, push});

  assign wr_ptr_inc = PW'(ptr_next(32'(wr_ptr_q), NOut));
  assign rd_ptr_inc = PW'(ptr_next(32'(rd_ptr_q), NOut));

  always_comb begin
    count_d = count_q;
    unique case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      total_q  <= '0;
    end else if (flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_inc;
        last_q   <= outData;
        if (total_q != '1) begin
          total_q <= total_q + CountWidth'(1);
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_inc;
      end
    end
  end

  // Storage write is gated by the same priority as the pointer update so a
  // discarded push never lands in the buffer.
  circular_buffer_mem #(
    .Width (MemoryElementWidth),
    .Depth (NOut)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push && !reset && !flush),
    .wr_addr (wr_ptr_q),
    .wr_data (outData),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign count    = count_q;
  assign lastOut  = last_q;
  assign totalOut = total_q;

endmodule

// File: tb/tb_out_channel_fifo.sv
module tb_out_channel_fifo;

  localparam int unsigned W   = 12;
  localparam int unsigned N   = 4;
  localparam int unsigned TCW = 4;   // narrow statistics counter to reach saturation quickly

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          outValid = 1'b0;
  logic [W-1:0]  outData = '0;
  logic          outReady;
  logic          drainValid;
  logic [W-1:0]  drainData;
  logic          drainReady = 1'b0;
  logic [2:0]    count;
  logic [W-1:0]  lastOut;
  logic [TCW-1:0] totalOut;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int unsigned m_q[$];
  int unsigned m_last = 0;
  int unsigned m_total = 0;

  out_channel_fifo #(
    .MemoryElementWidth (W),
    .NOut               (N),
    .CountWidth         (TCW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .outValid   (outValid),
    .outData    (outData),
    .outReady   (outReady),
    .drainValid (drainValid),
    .drainData  (drainData),
    .drainReady (drainReady),
    .count      (count),
    .lastOut    (lastOut),
    .totalOut   (totalOut)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("count",      32'(count),      m_q.size());
    check_eq("outReady",   32'(outReady),   (m_q.size() < N) ? 1 : 0);
    check_eq("drainValid", 32'(drainValid), (m_q.size() != 0) ? 1 : 0);
    check_eq("drainData",  32'(drainData),  (m_q.size() != 0) ? m_q[0] : 0);
    check_eq("lastOut",    32'(lastOut),    m_last);
    check_eq("totalOut",   32'(totalOut),   m_total);
  endtask

  // Apply one cycle of inputs, advance the model by the channel rules, check.
  task automatic cyc(input bit rst, input bit fl, input bit v,
                     input int unsigned d, input bit r);
    bit do_push, do_pop;
    reset = rst; flush = fl; outValid = v; outData = W'(d); drainReady = r;
    @(posedge clock);
    if (rst) begin
      m_q.delete(); m_last = 0; m_total = 0;
    end else if (fl) begin
      m_q.delete();
    end else begin
      do_push = v && (m_q.size() < N);
      do_pop  = r && (m_q.size() != 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(d);
        m_last = d;
        if (m_total < (1 << TCW) - 1) m_total++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_ready", 32'(outReady), 1);

    // Three pushes, no drain
    cyc(0, 0, 1, 10, 0);
    cyc(0, 0, 1, 20, 0);
    cyc(0, 0, 1, 30, 0);
    check_eq("p3_count", 32'(count), 3);
    check_eq("p3_head",  32'(drainData), 10);
    check_eq("p3_last",  32'(lastOut), 30);
    check_eq("p3_total", 32'(totalOut), 3);

    // Fill, then hold 50 against a full buffer
    cyc(0, 0, 1, 40, 0);
    cyc(0, 0, 1, 50, 0);
    cyc(0, 0, 1, 50, 0);
    check_eq("full_ready", 32'(outReady), 0);
    check_eq("full_last",  32'(lastOut), 40);
    cyc(0, 0, 1, 50, 1);            // pop while full: 50 still refused
    check_eq("full_pop_head",  32'(drainData), 20);
    check_eq("full_pop_count", 32'(count), 3);
    cyc(0, 0, 1, 50, 0);
    check_eq("late_accept", 32'(lastOut), 50);
    check_eq("late_count",  32'(count), 4);

    // Simultaneous push and pop at count 2
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 10, 0);
    cyc(0, 0, 1, 20, 0);
    cyc(0, 0, 1, 30, 1);
    check_eq("pp_count", 32'(count), 2);
    check_eq("pp_head",  32'(drainData), 20);
    cyc(0, 0, 0, 0, 1);
    check_eq("pp_head2", 32'(drainData), 30);

    // Wrap-around: values 1..10 streamed through
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    for (int i = 2; i <= 10; i++) begin
      check_eq("wrap_order", 32'(drainData), 32'(i - 1));
      cyc(0, 0, 1, i, 1);
    end
    check_eq("wrap_order", 32'(drainData), 10);
    cyc(0, 0, 0, 0, 1);
    check_eq("wrap_empty", 32'(drainValid), 0);

    // Flush with simultaneous push
    cyc(0, 0, 1, 7, 0);
    cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 9, 0);
    cyc(0, 1, 1, 99, 0);
    check_eq("fl_count", 32'(count), 0);
    check_eq("fl_valid", 32'(drainValid), 0);
    check_eq("fl_last",  32'(lastOut), 9);
    cyc(0, 0, 1, 5, 0);
    check_eq("fl_head",  32'(drainData), 5);

    // Reset mid-stream with outValid high
    cyc(0, 0, 1, 6, 0);
    cyc(1, 0, 1, 77, 1);
    check_eq("mr_count", 32'(count), 0);
    check_eq("mr_total", 32'(totalOut), 0);
    check_eq("mr_last",  32'(lastOut), 0);
    check_eq("mr_ready", 32'(outReady), 1);

    // Randomized traffic, includes statistics saturation
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 399) == 0),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 99) < 60),
          $urandom_range(0, (1 << W) - 1),
          ($urandom_range(0, 99) < 45));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
